// File: rtl/mpu_frame_assembler.sv
// Packs the first six bytes of each MPU6050 read burst into signed X/Y/Z words.
// Define MPU_FRAME_CAL_EN to build the averaging offset calibration.
module mpu_frame_assembler #(
   parameter int GAP_TIMEOUT = 2000
`ifdef MPU_FRAME_CAL_EN
   ,
   parameter int CAL_LOG2 = 4,
   parameter int CAL_Z = 0
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [7:0]         i_byte_in,
   input  logic               i_byte_valid,
   input  logic               i_frame_en,
   input  logic               i_cal_start,
   output logic signed [15:0] o_ax,
   output logic signed [15:0] o_ay,
   output logic signed [15:0] o_az,
   output logic               o_frame_valid,
   output logic [15:0]        o_frame_cnt,
   output logic               o_sync_err,
   output logic               o_cal_busy,
   output logic               o_cal_done
);
   localparam int GW = $clog2(GAP_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

   state_t             r_state, w_next;
   logic               r_valid_d, r_pend;
   logic [GW-1:0]      r_gap;
   logic [2:0]         r_idx, w_pos;
   logic [7:0]         r_buf [6];
   logic               w_edge, w_store, w_last, w_timeout, w_emit, w_show;
   logic signed [15:0] w_rawX, w_rawY, w_rawZ, w_outX, w_outY, w_outZ;

   assign w_edge    = i_byte_valid & ~r_valid_d;
   assign w_timeout = (r_state != S_IDLE) && !w_edge && (r_gap == GW'(GAP_TIMEOUT - 1));
   assign w_store   = i_frame_en && w_edge && (r_state != S_DRAIN);
   assign w_pos     = (r_state == S_IDLE) ? 3'd0 : r_idx;
   assign w_last    = w_store && (w_pos == 3'd5);
   assign w_emit    = r_pend && i_frame_en;
   assign w_rawX    = {r_buf[0], r_buf[1]};
   assign w_rawY    = {r_buf[2], r_buf[3]};
   assign w_rawZ    = {r_buf[4], r_buf[5]};

   always_comb begin
      w_next = r_state;
      if (!i_frame_en) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (w_edge) w_next = S_COLLECT;
            S_COLLECT: begin
               if (w_last) w_next = S_DRAIN;
               else if (w_timeout) w_next = S_IDLE;
            end
            S_DRAIN:   if (w_timeout) w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // The word is assembled on the 6th byte edge and published one clock later.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid_d  <= 1'b0;
         r_pend     <= 1'b0;
         r_gap      <= '0;
         r_idx      <= '0;
         o_sync_err <= 1'b0;
         for (int i = 0; i < 6; i++) r_buf[i] <= '0;
      end else begin
         r_valid_d  <= i_byte_valid;
         r_pend     <= w_last;
         o_sync_err <= i_frame_en && (r_state == S_COLLECT) && w_timeout;
         if (w_next == S_IDLE || w_edge) r_gap <= '0;
         else                            r_gap <= r_gap + GW'(1);
         if (w_store) begin
            r_buf[w_pos] <= i_byte_in;
            r_idx        <= w_pos + 3'd1;
         end
      end
   end

`ifdef MPU_FRAME_CAL_EN
   localparam int AW = 16 + CAL_LOG2;

   logic signed [AW-1:0]  r_accX, r_accY, r_accZ, w_sumX, w_sumY, w_sumZ;
   logic signed [15:0]    r_offX, r_offY, r_offZ;
   logic [CAL_LOG2-1:0]   r_calCnt;
   logic                  w_calStart;

   function automatic logic signed [15:0] satSub(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
      logic signed [16:0] d;
      d = {a[15], a} - {b[15], b};
      if (d[16] != d[15]) return d[16] ? 16'sh8000 : 16'sh7FFF;
      return d[15:0];
   endfunction

   assign w_calStart = i_cal_start && i_frame_en && !o_cal_busy;
   assign w_show     = w_emit && !o_cal_busy;
   assign w_sumX     = r_accX + {{CAL_LOG2{w_rawX[15]}}, w_rawX};
   assign w_sumY     = r_accY + {{CAL_LOG2{w_rawY[15]}}, w_rawY};
   assign w_sumZ     = r_accZ + {{CAL_LOG2{w_rawZ[15]}}, w_rawZ};
   assign w_outX     = satSub(w_rawX, r_offX);
   assign w_outY     = satSub(w_rawY, r_offY);
   assign w_outZ     = (CAL_Z != 0) ? satSub(w_rawZ, r_offZ) : w_rawZ;

   // Frames seen while busy only feed the accumulators; the average becomes the offset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_accX     <= '0;
         r_accY     <= '0;
         r_accZ     <= '0;
         r_offX     <= '0;
         r_offY     <= '0;
         r_offZ     <= '0;
         r_calCnt   <= '0;
         o_cal_busy <= 1'b0;
         o_cal_done <= 1'b0;
      end else begin
         o_cal_done <= 1'b0;
         if (!i_frame_en) begin
            o_cal_busy <= 1'b0;
         end else if (w_calStart) begin
            r_accX     <= '0;
            r_accY     <= '0;
            r_accZ     <= '0;
            r_calCnt   <= '0;
            o_cal_busy <= 1'b1;
         end else if (w_emit && o_cal_busy) begin
            r_accX   <= w_sumX;
            r_accY   <= w_sumY;
            r_accZ   <= w_sumZ;
            r_calCnt <= r_calCnt + CAL_LOG2'(1);
            if (&r_calCnt) begin
               r_offX     <= 16'(w_sumX >>> CAL_LOG2);
               r_offY     <= 16'(w_sumY >>> CAL_LOG2);
               r_offZ     <= 16'(w_sumZ >>> CAL_LOG2);
               o_cal_busy <= 1'b0;
               o_cal_done <= 1'b1;
            end
         end
      end
   end
`else
   logic w_unused;

   assign w_unused   = i_cal_start;
   assign w_show     = w_emit;
   assign w_outX     = w_rawX;
   assign w_outY     = w_rawY;
   assign w_outZ     = w_rawZ;
   assign o_cal_busy = 1'b0;
   assign o_cal_done = 1'b0;
`endif

   // The frame counter advances on every completed frame, shown or not.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ax          <= '0;
         o_ay          <= '0;
         o_az          <= '0;
         o_frame_valid <= 1'b0;
         o_frame_cnt   <= '0;
      end else begin
         o_frame_valid <= w_show;
         if (w_show) begin
            o_ax <= w_outX;
            o_ay <= w_outY;
            o_az <= w_outZ;
         end
         if (w_emit) o_frame_cnt <= o_frame_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_mpu_frame_assembler.sv
// Scoreboard bench for mpu_frame_assembler: a burst-level model predicts frames and sync errors.
// Build with MPU_FRAME_CAL_EN to also exercise the calibration path.
module tb_mpu_frame_assembler;
   localparam int GAP = 40;

   typedef struct {
      bit          isFrame;
      logic [15:0] ax, ay, az, cnt;
      int          cyc;
   } expect_t;

   logic        clock = 1'b0;
   logic        rstN, byteValid, frameEn, calStart;
   logic [7:0]  byteIn;
   logic [15:0] ax, ay, az, frameCnt;
   logic        frameValid, syncErr, calBusy, calDone;

   int          checks = 0, errors = 0, cyc = 0, calDoneSeen = 0;
   expect_t     expQ[$];
   expect_t     e;
   logic [7:0]  stimBytes[$];
   int          stimSpace[$], stimHold[$];
   logic [15:0] mcnt = 16'd0;
   logic [7:0]  burstBuf[6];
   int          burstLen = 0;
   bit          calMode = 1'b0;
   int          calFrames = 0, sumX = 0, sumY = 0, sumZ = 0, offX = 0, offY = 0;

   mpu_frame_assembler #(
      .GAP_TIMEOUT(GAP)
`ifdef MPU_FRAME_CAL_EN
      , .CAL_LOG2(2), .CAL_Z(0)
`endif
   ) dut (
      .i_clk(clock), .i_rst_n(rstN), .i_byte_in(byteIn), .i_byte_valid(byteValid),
      .i_frame_en(frameEn), .i_cal_start(calStart), .o_ax(ax), .o_ay(ay), .o_az(az),
      .o_frame_valid(frameValid), .o_frame_cnt(frameCnt), .o_sync_err(syncErr),
      .o_cal_busy(calBusy), .o_cal_done(calDone)
   );

   always #10 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] calOut(input logic [15:0] raw, input int off);
      int v;
      v = int'($signed(raw)) - off;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return 16'(v);
   endfunction

   // A completed burst either feeds the calibration average or becomes an expected frame.
   task automatic frameDone(input int evCyc);
      logic [15:0] rx, ry, rz;
      rx = {burstBuf[0], burstBuf[1]};
      ry = {burstBuf[2], burstBuf[3]};
      rz = {burstBuf[4], burstBuf[5]};
      mcnt++;
      if (calMode) begin
         sumX += int'($signed(rx));
         sumY += int'($signed(ry));
         sumZ += int'($signed(rz));
         calFrames++;
         if (calFrames == 4) begin
            offX = sumX >>> 2;
            offY = sumY >>> 2;
            calMode = 1'b0;
         end
      end else begin
         expQ.push_back('{1'b1, calOut(rx, offX), calOut(ry, offY), rz, mcnt, evCyc});
      end
   endtask

   task automatic modelByte(input logic [7:0] b, input int edgeCyc, input bit endsBurst);
      if (burstLen < 6) burstBuf[burstLen] = b;
      burstLen++;
      if (burstLen == 6) frameDone(edgeCyc + 1);
      if (endsBurst) begin
         if (burstLen < 6) expQ.push_back('{1'b0, 16'd0, 16'd0, 16'd0, mcnt, edgeCyc + GAP});
         burstLen = 0;
      end
   endtask

   task automatic addByte(input logic [7:0] b, input int hold, input int space);
      stimBytes.push_back(b);
      stimHold.push_back(hold);
      stimSpace.push_back(space);
   endtask

   task automatic addFrame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                           input int space);
      addByte(x[15:8], 1, space);
      addByte(x[7:0], 1, space);
      addByte(y[15:8], 1, space);
      addByte(y[7:0], 1, space);
      addByte(z[15:8], 1, space);
      addByte(z[7:0], 1, GAP + 2);
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < stimBytes.size(); i++) begin
         int edgeCyc;
         byteIn    = stimBytes[i];
         byteValid = 1'b1;
         edgeCyc   = cyc + 1;
         modelByte(stimBytes[i], edgeCyc, stimSpace[i] > GAP);
         @(negedge clock);
         byteIn = 8'($urandom);
         repeat (stimHold[i] - 1) @(negedge clock);
         byteValid = 1'b0;
         repeat (stimSpace[i] - stimHold[i]) @(negedge clock);
      end
      stimBytes.delete();
      stimHold.delete();
      stimSpace.delete();
   endtask

   // Every frame_valid or sync_err pulse must match the oldest outstanding prediction.
   always @(negedge clock) begin
      if (rstN) begin
         if (calDone) calDoneSeen++;
         if (frameValid || syncErr) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedEvent: actual frameValid=%0b syncErr=%0b required none",
                        frameValid, syncErr);
            end else begin
               e = expQ.pop_front();
               checkOutput("eventKind", {31'd0, frameValid}, {31'd0, e.isFrame});
               checkOutput("eventCycle", cyc, e.cyc);
               checkOutput("frameCnt", {16'd0, frameCnt}, {16'd0, e.cnt});
               if (e.isFrame) begin
                  checkOutput("ax", {16'd0, ax}, {16'd0, e.ax});
                  checkOutput("ay", {16'd0, ay}, {16'd0, e.ay});
                  checkOutput("az", {16'd0, az}, {16'd0, e.az});
               end
            end
         end
      end
   end

   initial begin
      repeat (100000) @(posedge clock);
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN = 1'b0;
      byteIn = 8'd0;
      byteValid = 1'b0;
      frameEn = 1'b1;
      calStart = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("rstAx", {16'd0, ax}, 32'd0);
      checkOutput("rstAy", {16'd0, ay}, 32'd0);
      checkOutput("rstAz", {16'd0, az}, 32'd0);
      checkOutput("rstCnt", {16'd0, frameCnt}, 32'd0);
      checkOutput("rstValid", {31'd0, frameValid}, 32'd0);
      checkOutput("rstSync", {31'd0, syncErr}, 32'd0);
      checkOutput("rstBusy", {31'd0, calBusy}, 32'd0);
      checkOutput("rstDone", {31'd0, calDone}, 32'd0);
      rstN = 1'b1;
      repeat (2) @(negedge clock);

      addFrame(16'h1234, 16'hFEDC, 16'h4000, 25);
      applyStimulus();

      addByte(8'hA1, 1, 10);
      addByte(8'hA2, 2, 12);
      addByte(8'hA3, 1, GAP + 5);
      addFrame(16'h7FFF, 16'h8000, 16'h0001, 7);
      applyStimulus();

      for (int i = 0; i < 7; i++) addByte(8'(8'h30 + i), 3, (i == 6) ? GAP + 3 : 6);
      applyStimulus();

      addByte(8'h11, 1, 5);
      addByte(8'h22, 1, GAP);
      addByte(8'h33, 1, 5);
      addByte(8'h44, 1, GAP + 1);
      addByte(8'h55, 1, GAP);
      addByte(8'h66, 2, 4);
      addByte(8'h77, 1, 3);
      addByte(8'h88, 1, 3);
      addByte(8'h99, 1, 3);
      addByte(8'hAA, 1, GAP + 4);
      applyStimulus();

      for (int i = 0; i < 4; i++) addByte(8'(8'hC0 + i), 1, 5);
      applyStimulus();
      frameEn = 1'b0;
      burstLen = 0;
      repeat (3) @(negedge clock);
      frameEn = 1'b1;
      repeat (GAP + 5) @(negedge clock);
      addFrame(16'h0102, 16'h0304, 16'h0506, 9);
      applyStimulus();

      for (int b = 0; b < 15; b++) begin
         int len;
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            int hold;
            hold = $urandom_range(1, 3);
            addByte(8'($urandom), hold,
                    (i == len - 1) ? GAP + 1 + $urandom_range(0, 8) : $urandom_range(hold + 1, GAP));
         end
         applyStimulus();
      end

      force dut.o_frame_cnt = 16'hFFFF;
      @(negedge clock);
      release dut.o_frame_cnt;
      mcnt = 16'hFFFF;
      addFrame(16'hBEEF, 16'h0BAD, 16'hCAFE, 4);
      applyStimulus();

`ifdef MPU_FRAME_CAL_EN
      calStart = 1'b1;
      @(negedge clock);
      calStart = 1'b0;
      checkOutput("calBusyStart", {31'd0, calBusy}, 32'd1);
      calMode = 1'b1;
      for (int k = 0; k < 4; k++) addFrame(16'(16'h0010 + 2 * k), 16'($urandom), 16'($urandom), 5);
      applyStimulus();
      checkOutput("calDoneCount", calDoneSeen, 32'd1);
      checkOutput("calBusyEnd", {31'd0, calBusy}, 32'd0);
      addFrame(16'h8000, 16'h0100, 16'h4000, 5);
      applyStimulus();
`endif

      repeat (GAP + 10) @(negedge clock);
      checkOutput("queueEmpty", expQ.size(), 32'd0);
      checkOutput("finalCnt", {16'd0, frameCnt}, {16'd0, mcnt});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
